// File: rtl/mux_rr_select_arbiter_pkg.sv
// Shared constants and types for the round-robin mux select arbiter.
package mux_rr_select_arbiter_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [SEL_W-1:0]  select;
        logic [NUM_CH-1:0] grant;
        logic              valid;
        logic              timeout;
    } arb_out_t;

endpackage

// File: rtl/mux_rr_select_arbiter_pick.sv
// Combinational round-robin pick: first set request scanning from last+1 around to last.
module rr_priority_pick
    import mux_rr_select_arbiter_pkg::*;
#(
    parameter int N = NUM_CH,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         any
);

    int idx;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        winner = '0;
        any    = |req;
        idx    = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[idx]) winner = W'(idx);
        end
    end

endmodule

// File: rtl/mux_rr_select_arbiter.sv
// Round-robin select generator for a 4:1 mux with hold timeout and a guard cycle between grants.
// The consumer release pulse is named rel because release is a reserved word.
module mux_rr_select_arbiter
    import mux_rr_select_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              rel,
    output logic [SEL_W-1:0]  select,
    output logic [NUM_CH-1:0] grant,
    output logic              valid,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255 || (2 ** CNT_W) <= HOLD_CYCLES) begin : g_bad_param
        $error("mux_rr_select_arbiter: illegal HOLD_CYCLES/CNT_W");
    end

    arb_state_e       state_q, state_d;
    arb_out_t         out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] winner;
    logic             any;
    logic             drop;

    rr_priority_pick #(.N(NUM_CH), .W(SEL_W)) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    assign drop = !req[out_q.select];

    always_comb begin
        state_d       = state_q;
        out_d         = out_q;
        out_d.timeout = 1'b0;
        cnt_d         = cnt_q;
        last_d        = last_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    out_d.select = winner;
                    out_d.grant  = NUM_CH'(1) << winner;
                    out_d.valid  = 1'b1;
                    last_d       = winner;
                    cnt_d        = '0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (rel || drop || cnt_q == HOLD_LAST) begin
                    out_d.grant   = '0;
                    out_d.valid   = 1'b0;
                    // Timeout is reported only when the hold limit alone ended the grant.
                    out_d.timeout = !rel && !drop;
                    state_d       = GUARD;
                end
            end
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            last_q  <= SEL_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign select  = out_q.select;
    assign grant   = out_q.grant;
    assign valid   = out_q.valid;
    assign timeout = out_q.timeout;

endmodule

// File: tb/tb_mux_rr_select_arbiter.sv
// Table-driven bench with a scoreboard queue for the round-robin mux select arbiter.
module tb_mux_rr_select_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [1:0] select;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       vld;
        logic       to;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rel;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    mux_rr_select_arbiter #(.HOLD_CYCLES(16), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .select  (select),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq, input logic rl,
                       input logic [1:0] s, input logic [3:0] g, input logic v, input logic t);
        vec_t x;
        x.rst = r; x.req = rq; x.rel = rl;
        x.exp = '{sel: s, gnt: g, vld: v, to: t};
        vecs.push_back(x);
    endtask

    // Drive one cycle, queue its expectation, then check it just after the edge.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic rl,
                       input exp_t e, input string name);
        exp_t want;
        exp_t got;
        @(negedge clk);
        rst = r; req = rq; rel = rl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = '{sel: select, gnt: grant, vld: valid, to: timeout};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got sel=%0d grant=%b valid=%b timeout=%b, want sel=%0d grant=%b valid=%b timeout=%b",
                     name, got.sel, got.gnt, got.vld, got.to, want.sel, want.gnt, want.vld, want.to);
        end
        checks++;
        if (valid !== (|grant)) begin
            failures++;
            $display("FAIL %s_valid_eq_or_grant: valid=%b grant=%b", name, valid, grant);
        end
    endtask

    initial begin
        int ch;
        exp_t e;
        rst = 1'b1; req = '0; rel = 1'b0;

        // Reset and first grant
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b0101, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b0101, 0, 0, 4'b0001, 1, 0);
        // Fairness: ch0, ch2, ch0, ch2, release three cycles into each grant
        for (int g = 0; g < 4; g++) begin
            ch = (g % 2 == 0) ? 0 : 2;
            if (g > 0) add(0, 4'b0101, 0, 2'(ch), 4'b0001 << ch, 1, 0);
            add(0, 4'b0101, 0, 2'(ch), 4'b0001 << ch, 1, 0);
            add(0, 4'b0101, 0, 2'(ch), 4'b0001 << ch, 1, 0);
            add(0, 4'b0101, 1, 2'(ch), 4'b0000, 0, 0);
            add(0, 4'b0101, 0, 2'(ch), 4'b0000, 0, 0);
        end
        // Release in IDLE is ignored
        add(0, 4'b0000, 1, 2, 4'b0000, 0, 0);
        // Requester drop on ch1; select holds through GUARD
        add(0, 4'b0010, 0, 1, 4'b0010, 1, 0);
        add(0, 4'b0010, 0, 1, 4'b0010, 1, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 0);
        // Non-granted request changes are ignored mid-grant
        add(0, 4'b0100, 0, 2, 4'b0100, 1, 0);
        add(0, 4'b1111, 0, 2, 4'b0100, 1, 0);
        // Reset mid-grant, then ch0 first from 1111
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 0, 4'b0001, 1, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0010, 1, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 0);
        add(0, 4'b1000, 0, 1, 4'b0000, 0, 0);
        // Pointer at 1 with req=1001: scan 2,3 -> ch3, then wrap gives ch0
        add(0, 4'b1001, 0, 3, 4'b1000, 1, 0);
        add(0, 4'b1001, 1, 3, 4'b0000, 0, 0);
        add(0, 4'b1001, 0, 3, 4'b0000, 0, 0);
        add(0, 4'b1001, 0, 0, 4'b0001, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            cyc(vecs[i].rst, vecs[i].req, vecs[i].rel, vecs[i].exp, $sformatf("vec%0d", i));

        // Timeout: ch3 held alone, 16 valid cycles, pulse, then regrant after GUARD+IDLE
        cyc(1, 4'b0000, 0, '{sel: 0, gnt: 4'b0000, vld: 0, to: 0}, "to_reset");
        for (int i = 0; i <= 36; i++) begin
            int p;
            p = i % 18;
            e = '{sel: 3, gnt: (p < 16) ? 4'b1000 : 4'b0000, vld: (p < 16), to: (p == 16)};
            cyc(0, 4'b1000, 0, e, $sformatf("timeout_c%0d", i));
        end

        // Release on the hold-limit edge: grant ends, no timeout
        for (int i = 1; i <= 15; i++)
            cyc(0, 4'b1000, 0, '{sel: 3, gnt: 4'b1000, vld: 1, to: 0}, $sformatf("sim_rel_c%0d", i));
        cyc(0, 4'b1000, 1, '{sel: 3, gnt: 4'b0000, vld: 0, to: 0}, "sim_rel_exit");
        cyc(0, 4'b1000, 0, '{sel: 3, gnt: 4'b0000, vld: 0, to: 0}, "sim_rel_guard");
        cyc(0, 4'b1000, 0, '{sel: 3, gnt: 4'b1000, vld: 1, to: 0}, "sim_drop_grant");

        // Request drop on the hold-limit edge: grant ends, no timeout
        for (int i = 1; i <= 15; i++)
            cyc(0, 4'b1000, 0, '{sel: 3, gnt: 4'b1000, vld: 1, to: 0}, $sformatf("sim_drop_c%0d", i));
        cyc(0, 4'b0000, 0, '{sel: 3, gnt: 4'b0000, vld: 0, to: 0}, "sim_drop_exit");
        cyc(0, 4'b0000, 0, '{sel: 3, gnt: 4'b0000, vld: 0, to: 0}, "sim_drop_guard");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
